id_ex_pipe: RTL
===============

// Module: id_ex_pipe
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32I core. Captures the 15-bit decoded control word, operands and
//  register indices from decode and presents them to execute. Also detects load-use hazards, emits the
//  decode/fetch stall and inserts bubbles. Applies branch/jump flushes from EX.
// PARAMETERS
//  XLEN    32  datapath width
//  CTRL_W  15  control word width
//  CNT_W   16  bubble/flush performance counter width
// PORTS
//  clk            in   1       core clock; all state updates on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  id_valid       in   1       decode slot holds a real instruction
//  id_ctrl        in   CTRL_W  decoded control word (layout below)
//  id_pc          in   XLEN    PC of decode instruction
//  id_rs1_data    in   XLEN    register file read port 1
//  id_rs2_data    in   XLEN    register file read port 2
//  id_imm         in   XLEN    sign-extended immediate
//  id_rs1,id_rs2  in   5       source indices
//  id_rd          in   5       destination index
//  id_funct3      in   3       instr[14:12]
//  id_funct7b5    in   1       instr[30]
//  ex_flush       in   1       EX resolved taken branch/jump; kill slot being loaded
//  hold           in   1       external freeze (data memory wait); register keeps contents
//  load_stall     out  1       combinational; load-use hazard, PC and IF/ID must hold
//  ex_valid       out  1       registered copy of the slot's valid
//  ex_ctrl        out  CTRL_W  registered control word
//  ex_pc,ex_rs1_data,ex_rs2_data,ex_imm  out XLEN  registered operands
//  ex_rs1,ex_rs2,ex_rd  out 5  registered indices (for forwarding unit)
//  ex_funct3      out  3       registered; ex_funct7b5 out 1 registered
//  bubble_cnt     out  CNT_W   count of load-use bubbles inserted
//  flush_cnt      out  CNT_W   count of flushed slots
// BEHAVIOUR
//  Control word bits: [1:0] immsel lo, [2] AluSrc, [3] MemToReg, [4] RegWrite, [5] MemRead, [6] MemWrite,
//   [7] Branch, [10:8] AluOp, [11] immsel[2], [12] offset-to-reg, [13] jalr, [14] unconditional jump.
//  Reset (reset_n=0, immediate, async): all registered outputs and both counters go to 0. A zero slot is a NOP bubble.
//  load_stall = ex_valid & ex_ctrl[5] & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
//   Both rs fields are compared regardless of format. False stalls on unused rs2 are accepted.
//  Per-edge update, priority high->low:
//   1 ex_flush: ex_valid<=0, ex_ctrl<=0; other fields don't care; flush_cnt++ if id_valid. Overrides hold.
//   2 hold (no flush): every register keeps its value; counters unchanged; load_stall is still computed.
//   3 load_stall: bubble; ex_valid<=0, ex_ctrl<=0; bubble_cnt++.
//   4 otherwise: load all id_* fields; ex_ctrl<=id_valid ? id_ctrl : 0; ex_valid<=id_valid.
//  Latency is 1 cycle, decode to execute. A load-use pair costs exactly 1 bubble: after the bubble, ex_ctrl[5]=0,
//   so load_stall drops.
//  Counters saturate at all-ones and never wrap.
//  Invariant: ex_valid=0 implies ex_ctrl==0, so no RegWrite, MemWrite or Branch reaches EX from a bubble.
//  Reset mid-stall: load_stall goes to 0 at once, because ex_valid=0.
// STRUCTURE
//  Shared package/header core_defs: control bit index constants (CTRL_MEMREAD=5, CTRL_REGWRITE=4, ...),
//   CTRL_W, and the opcode defines. Decoder and this block both use it.
//  One sub-module: hazard_detect (pure combinational, produces load_stall). Counters and register are inline.
// TESTING
//  Reset: assert reset_n=0 mid-cycle -> all outputs 0 before the next edge; release -> first edge loads decode.
//  Pass-through: id_ctrl=15'h0410, rd=5, pc=0x100, id_valid=1 -> next cycle ex_ctrl=15'h0410, ex_rd=5, ex_pc=0x100.
//  Load-use: EX holds lw x5 (ctrl[5]=1, rd=5) and ID has add x6,x5,x7 -> load_stall=1.
//   Next edge: ex_ctrl=0, bubble_cnt=1. Following edge: the add enters EX with load_stall=0.
//  x0 exemption: EX holds lw x0 and ID reads x0 -> load_stall=0, no bubble.
//  Flush vs hold: ex_flush=1 and hold=1 on the same edge -> ex_valid=0, ex_ctrl=0, flush_cnt increments.
//   With hold=1 alone for 3 cycles -> outputs are unchanged.
//  Saturation: preload bubble_cnt to 16'hFFFF and force one more bubble -> count stays 16'hFFFF.

Source files
------------

// File: rtl/core_defs.sv
// rtl/core_defs.sv - shared RV32I core definitions: control word layout and opcodes
package core_defs;

    localparam int CTRL_W = 15;

    localparam int CTRL_IMMSEL_LO = 0;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_REGWRITE  = 4;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_BRANCH    = 7;
    localparam int CTRL_ALUOP_LO  = 8;
    localparam int CTRL_IMMSEL_HI = 11;
    localparam int CTRL_OFS2REG   = 12;
    localparam int CTRL_JALR      = 13;
    localparam int CTRL_JUMP      = 14;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection between the EX slot and decode
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       load_stall_o
);

    // rs2 is compared even for formats that ignore it; a rare false stall is cheaper than decoding format here.
    assign load_stall_o = ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0) & id_valid_i &
                          ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use bubbling, flush and perf counters
module id_ex_pipe
    import core_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              load_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              ex_valid_q,    ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
    logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
    logic [4:0]        ex_rs1_q,      ex_rs1_d;
    logic [4:0]        ex_rs2_q,      ex_rs2_d;
    logic [4:0]        ex_rd_q,       ex_rd_d;
    logic [2:0]        ex_funct3_q,   ex_funct3_d;
    logic              ex_funct7b5_q, ex_funct7b5_d;
    logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

    hazard_detect u_hazard_detect (
        .ex_valid_i   (ex_valid_q),
        .ex_memread_i (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rd_i      (ex_rd_q),
        .id_valid_i   (id_valid),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .load_stall_o (load_stall)
    );

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_funct3_d   = ex_funct3_q;
        ex_funct7b5_d = ex_funct7b5_q;
        bubble_cnt_d  = bubble_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        // Flush wins over hold so a wrong-path instruction can never survive a memory wait.
        if (ex_flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (id_valid && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (!hold) begin
            if (load_stall) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end else begin
                ex_valid_d    = id_valid;
                ex_ctrl_d     = id_valid ? id_ctrl : '0;
                ex_pc_d       = id_pc;
                ex_rs1_data_d = id_rs1_data;
                ex_rs2_data_d = id_rs2_data;
                ex_imm_d      = id_imm;
                ex_rs1_d      = id_rs1;
                ex_rs2_d      = id_rs2;
                ex_rd_d       = id_rd;
                ex_funct3_d   = id_funct3;
                ex_funct7b5_d = id_funct7b5;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_funct3_q   <= '0;
            ex_funct7b5_q <= 1'b0;
            bubble_cnt_q  <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_funct7b5_q <= ex_funct7b5_d;
            bubble_cnt_q  <= bubble_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_funct3   = ex_funct3_q;
    assign ex_funct7b5 = ex_funct7b5_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
